regfile_dump: RTL and testbench
===============================

# regfile_dump

Debug reader for the processor register file: on request, it walks all 32 registers X0–X31 through a dedicated asynchronous read port. It streams each value out, with its index, over a valid/ready handshake. It sits beside `regfile` and drives that block's debug read address. It consumes the asynchronous read data and never writes the register file. X31 (XZR) is always reported as zero, whatever the array holds.

## Interface
Parameters:
- N, 64, register data width; must match the connected `regfile`.

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-low reset (reset = 0 clears the block immediately)
- start  in  1  dump request; sampled only in IDLE
- busy  out  1  high from the first FETCH through DONE
- done  out  1  one-cycle pulse after the last register is accepted
- ra  out  5  read address to the register-file debug port
- rd  in  N  asynchronous read data returned for `ra`
- out_valid  out  1  `out_idx`/`out_data` hold a register value
- out_ready  in  1  downstream accepts the value when both valid and ready are high at a rising edge
- out_idx  out  5  register index of the current value
- out_data  out  N  register value; 0 when `out_idx` = 31

## Operation
Internal state: `state` ∈ {IDLE, FETCH, PRESENT, DONE}, 5-bit index `idx`.

- IDLE
  - busy=0, out_valid=0, done=0, ra=0.
  - start=1 at an edge → FETCH, idx←0.
- FETCH
  - ra=idx, busy=1.
  - At the next edge, unconditionally:
    - out_data←(idx==31 ? 0 : rd), out_idx←idx, out_valid←1.
    - → PRESENT.
- PRESENT
  - ra=idx; out_valid, out_idx and out_data stay stable until accepted.
  - Edge with out_ready=1: out_valid←0.
    - If idx==31 → DONE.
    - Else idx←idx+1 → FETCH.
  - out_ready=0: remain in PRESENT, no change.
- DONE
  - done=1, busy=1, out_valid=0.
  - Next edge → IDLE.
- `start` is ignored outside IDLE, including during DONE. No queuing of requests.
- Each value is the register content at its own FETCH edge. Writes to the register file during a dump are visible for registers not yet fetched; no global snapshot is taken.
- Index arithmetic is 5-bit and never wraps: termination is decided on idx==31, before any increment.
- The block writes nothing to the register file, and no write-enable path exists.

## Timing
- Reset (reset=0, asynchronous, any state) takes effect immediately: state=IDLE, idx=0, out_valid=0, out_idx=0, out_data=0, done=0, busy=0, ra=0.
  - Reset mid-dump abandons the dump; the first edge after release resumes normal IDLE behaviour.
- Latency from the start edge (t0):
  - FETCH runs in cycle t0..t1.
  - out_valid rises after edge t1.
- Throughput: at most one register per 2 cycles (FETCH + PRESENT), with out_ready held high.
- Full dump with out_ready held high:
  - Last acceptance at edge t0+64.
  - done high in cycle t0+64..t0+65.
  - IDLE after edge t0+65.
- Backpressure adds one cycle per stalled cycle. Outputs must not change while out_valid=1 and out_ready=0.
- `rd` is combinational from `ra`. It is only required to settle within the FETCH cycle, and `ra` is stable for that whole cycle.
- out_ready while out_valid=0 has no effect.

## Test plan
- Reset contents (X[i]=i, X31 stored 0), start pulse, out_ready=1 → 32 transfers:
  - idx 0..31 with data 0..30 then 0.
  - done high exactly at cycle t0+64; busy low after t0+65.
- Preload X31 with 0xDEAD through the array backdoor, dump → idx 31 is reported with out_data=0.
- out_ready toggled randomly, with a 5-cycle stall on idx 7 → idx 7 data=7 held stable all 5 cycles; no index skipped or duplicated.
- Register-file write X5←0xABCD at a cycle before idx 5's FETCH → reported data 0xABCD. The same write after idx 5 is accepted → reported data 5.
- Reset asserted while PRESENT on idx 12 → outputs zero immediately. A new start after release restarts at idx 0.
- start held high continuously → back-to-back dumps, with one IDLE cycle between the done pulse and the next FETCH. start pulses mid-dump are ignored.

Source files
------------

// File: rtl/regfile_dump.sv
// Debug walker: streams X0..X31 (XZR forced to 0) over valid/ready, one value per FETCH+PRESENT pair.
// First value valid one cycle after the start edge; out_valid/out_idx/out_data hold while out_ready is low.
module regfile_dump #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic [4:0]   ra,
  input  logic [N-1:0] rd,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [4:0]   out_idx,
  output logic [N-1:0] out_data
);

  typedef enum logic [1:0] {IDLE, FETCH, PRESENT, DONE} state_t;

  localparam logic [4:0] LAST = 5'd31;

  state_t     state;
  logic [4:0] idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      idx       <= '0;
      ra        <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done      <= 1'b0;
          out_valid <= 1'b0;
          ra        <= '0;
          if (start) begin
            state <= FETCH;
            idx   <= '0;
            busy  <= 1'b1;
          end else begin
            busy  <= 1'b0;
          end
        end
        FETCH: begin
          // rd has settled on ra=idx for the whole cycle; capture it now
          out_data  <= (idx == LAST) ? '0 : rd;
          out_idx   <= idx;
          out_valid <= 1'b1;
          state     <= PRESENT;
        end
        PRESENT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (idx == LAST) begin
              state <= DONE;
              done  <= 1'b1;
              ra    <= '0;
            end else begin
              idx   <= idx + 5'd1;
              ra    <= idx + 5'd1;
              state <= FETCH;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          idx   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump with a behavioural register array on the debug read port.
module tb_regfile_dump;
  localparam int N = 64;

  logic         clk;
  logic         reset;
  logic         start;
  logic         busy;
  logic         done;
  logic [4:0]   ra;
  logic [N-1:0] rd;
  logic         out_valid;
  logic         out_ready;
  logic [4:0]   out_idx;
  logic [N-1:0] out_data;

  logic [N-1:0] rf       [32];
  logic [N-1:0] exp_data [32];
  int checks   = 0;
  int failures = 0;

  assign rd = rf[ra];

  regfile_dump #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .ra        (ra),
    .rd        (rd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=no_finish required=finish");
    $fatal(1, "simulation time limit reached");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_exp();
    for (int i = 0; i < 32; i++) exp_data[i] = (i == 31) ? 64'd0 : 64'(i);
  endtask

  // Full dump with out_ready high; optional write of X5 before tick number wr_cyc.
  task automatic dump_full(input int wr_cyc, input logic hold);
    start     = 1'b1;
    out_ready = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    chk("t0_ctl", 64'({out_valid, busy, done}), 64'(3'b010));
    chk("t0_ra", 64'(ra), 64'd0);
    for (int k = 1; k <= 65; k++) begin
      if (k == wr_cyc) rf[5] = 64'hABCD;
      tick();
      if (k <= 63 && (k % 2) == 1) begin
        int i;
        i = (k - 1) / 2;
        chk($sformatf("present_ctl k=%0d", k), 64'({out_valid, busy, done}), 64'(3'b110));
        chk($sformatf("present_ra k=%0d", k), 64'(ra), 64'(i));
        chk($sformatf("present_idx k=%0d", k), 64'(out_idx), 64'(i));
        chk($sformatf("present_data k=%0d", k), out_data, exp_data[i]);
      end else if (k <= 62) begin
        chk($sformatf("fetch_ctl k=%0d", k), 64'({out_valid, busy, done}), 64'(3'b010));
        chk($sformatf("fetch_ra k=%0d", k), 64'(ra), 64'(k / 2));
      end else if (k == 64) begin
        chk("done_ctl k=64", 64'({out_valid, busy, done}), 64'(3'b011));
      end else begin
        chk("idle_ctl k=65", 64'({out_valid, busy, done}), 64'(3'b000));
        chk("idle_ra k=65", 64'(ra), 64'd0);
      end
    end
  endtask

  initial begin
    int exp_i;
    int stall;
    int cyc;

    reset     = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = (i == 31) ? 64'd0 : 64'(i);

    // Reset state
    #1 reset = 1'b0;
    #2;
    chk("rst_ctl", 64'({out_valid, busy, done}), 64'd0);
    chk("rst_ra_idx", 64'({ra, out_idx}), 64'd0);
    chk("rst_data", out_data, 64'd0);
    start = 1'b1;
    tick();
    tick();
    chk("rst_hold_ctl", 64'({out_valid, busy, done}), 64'd0);
    start = 1'b0;
    reset = 1'b1;
    tick();
    chk("idle_ctl", 64'({out_valid, busy, done}), 64'd0);

    // Plain dump of X[i]=i
    set_exp();
    dump_full(-1, 1'b0);

    // XZR forced to zero even when the array holds a value
    rf[31] = 64'hDEAD;
    dump_full(-1, 1'b0);

    // Random backpressure with a 5-cycle stall on idx 7
    exp_i = 0;
    stall = 0;
    cyc   = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (!done && cyc < 1500) begin
      if (out_valid && out_idx == 5'd7 && stall < 5) begin
        chk($sformatf("stall_idx s=%0d", stall), 64'(out_idx), 64'd7);
        chk($sformatf("stall_data s=%0d", stall), out_data, 64'd7);
        out_ready = 1'b0;
        stall++;
      end else if (out_valid) begin
        out_ready = 1'($urandom_range(0, 1));
        if (out_ready) begin
          chk($sformatf("rand_idx n=%0d", exp_i), 64'(out_idx), 64'(exp_i));
          chk($sformatf("rand_data n=%0d", exp_i), out_data, (exp_i == 31) ? 64'd0 : 64'(exp_i));
          exp_i++;
        end
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
      tick();
      cyc++;
    end
    chk("rand_done", 64'(done), 64'd1);
    chk("rand_count", 64'(exp_i), 64'd32);
    chk("rand_stall", 64'(stall), 64'd5);
    out_ready = 1'b0;
    tick();
    chk("rand_idle", 64'({out_valid, busy, done}), 64'd0);

    // X5 written before its FETCH edge is reported with the new value
    set_exp();
    exp_data[5] = 64'hABCD;
    dump_full(6, 1'b0);

    // X5 written after its acceptance: old value already captured
    rf[5] = 64'd5;
    set_exp();
    dump_full(14, 1'b0);
    rf[5] = 64'd5;

    // start held high: back-to-back dumps with one IDLE cycle between
    set_exp();
    dump_full(-1, 1'b1);
    tick();
    chk("b2b_fetch_ctl", 64'({out_valid, busy, done}), 64'(3'b010));
    chk("b2b_fetch_ra", 64'(ra), 64'd0);
    start = 1'b0;
    for (int k = 0; k < 25; k++) tick();
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    chk("pre_rst_idx", 64'(out_idx), 64'd12);
    chk("pre_rst_data", out_data, 64'd12);

    // Asynchronous reset while presenting idx 12
    reset = 1'b0;
    #1;
    chk("mid_rst_ctl", 64'({out_valid, busy, done}), 64'd0);
    chk("mid_rst_ra_idx", 64'({ra, out_idx}), 64'd0);
    chk("mid_rst_data", out_data, 64'd0);
    #2 reset = 1'b1;
    tick();
    chk("post_rst_idle", 64'({out_valid, busy, done}), 64'd0);

    // Fresh dump restarts at idx 0
    dump_full(-1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
